// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (instruction/data) arbiter onto one shared memory port
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   ireq_*/iresp_*                   instruction fetch port (valid/addr_ok/data_ok)
//   dreq_*/dresp_*                   data memory port (valid/addr_ok/data_ok)
//   mreq_*/mresp_*                   shared memory port
//   busy                             high whenever a transaction is in ADDR or DATA
//
// One transaction is outstanding at most. Data normally wins a collision, but
// after D_STREAK_MAX consecutive data grants with a fetch waiting, the fetch
// is granted next.
module mem_bus_arbiter #(
    parameter int D_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ireq_valid,
    input  logic [31:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [31:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [3:0]  dreq_strobe,
    input  logic [31:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [31:0] dresp_data,
    output logic        mreq_valid,
    output logic [31:0] mreq_addr,
    output logic [2:0]  mreq_size,
    output logic [3:0]  mreq_strobe,
    output logic [31:0] mreq_data,
    input  logic        mresp_addr_ok,
    input  logic        mresp_data_ok,
    input  logic [31:0] mresp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_MAX = 4'(D_STREAK_MAX);

    state_e     state_q, state_d;
    logic       owner_d_q, owner_d_d;   // 1: data side owns the bus, 0: instruction side
    logic [3:0] streak_q, streak_d;

    // IDLE grant selection
    logic sel_valid;
    logic sel_d;
    logic grant;
    // Side currently routed: the selection in IDLE, the latched owner otherwise
    logic cur_d;
    logic route_valid;

    always_comb begin
        sel_valid = ireq_valid | dreq_valid;
        sel_d     = dreq_valid & (~ireq_valid | (streak_q != STREAK_MAX));
        grant     = (state_q == ST_IDLE) & sel_valid;
        cur_d     = (state_q == ST_IDLE) ? sel_d : owner_d_q;
        // A stray data_ok in IDLE with nothing selected must reach nobody
        route_valid = grant | (state_q != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            owner_d_q <= 1'b0;
            streak_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_d_q <= owner_d_d;
            streak_q  <= streak_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        owner_d_d = owner_d_q;
        streak_d  = streak_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d_d = sel_d;
                    if (mresp_addr_ok && mresp_data_ok) begin
                        state_d = ST_IDLE;
                    end else if (mresp_addr_ok) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ADDR;
                    end
                    // Streak only grows while a fetch is actually being held off
                    if (sel_d && ireq_valid) begin
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end
            end
            ST_ADDR: begin
                if (mresp_addr_ok) begin
                    state_d = mresp_data_ok ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (mresp_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mreq_valid    = 1'b0;
        mreq_addr     = 32'd0;
        mreq_size     = 3'd0;
        mreq_strobe   = 4'd0;
        mreq_data     = 32'd0;
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        iresp_data    = mresp_data;
        dresp_data    = mresp_data;
        busy          = (state_q != ST_IDLE);

        if (grant || (state_q == ST_ADDR)) begin
            mreq_valid = 1'b1;
            if (cur_d) begin
                mreq_addr   = dreq_addr;
                mreq_size   = dreq_size;
                mreq_strobe = dreq_strobe;
                mreq_data   = dreq_data;
            end else begin
                // Fetches are always word reads
                mreq_addr   = ireq_addr;
                mreq_size   = 3'b010;
            end
        end

        if (route_valid) begin
            if (cur_d) begin
                dresp_addr_ok = mresp_addr_ok;
                dresp_data_ok = mresp_data_ok;
            end else begin
                iresp_addr_ok = mresp_addr_ok;
                iresp_data_ok = mresp_data_ok;
            end
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the core's instruction fetch port and data memory port onto one shared memory port. Requests are served one at a time, with data requests normally taking priority. A streak limit stops a run of data requests from starving instruction fetch. The block sits between the pipeline's fetch/memory stages and the external memory interface, and uses the same valid/addr_ok/data_ok split handshake on every port.

## Interface
- D_STREAK_MAX, default 4: maximum consecutive data grants made while an instruction request is waiting. Range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- ireq_valid  in  1  instruction request valid; held until iresp_addr_ok.
- ireq_addr  in  32  instruction address.
- iresp_addr_ok  out  1  address accepted for the instruction request.
- iresp_data_ok  out  1  instruction data valid.
- iresp_data  out  32  instruction word.
- dreq_valid  in  1  data request valid; held until dresp_addr_ok.
- dreq_addr  in  32  data address.
- dreq_size  in  3  access size code.
- dreq_strobe  in  4  byte write strobes; 0 means read.
- dreq_data  in  32  write data.
- dresp_addr_ok  out  1  address accepted for the data request.
- dresp_data_ok  out  1  data phase complete.
- dresp_data  out  32  read data.
- mreq_valid, mreq_addr[32], mreq_size[3], mreq_strobe[4], mreq_data[32]  out  shared request to memory.
- mresp_addr_ok, mresp_data_ok  in  1 each  memory handshake.
- mresp_data  in  32  memory read data.
- busy  out  1  high whenever state is not IDLE.

## Operation
- State machine: IDLE, ADDR, DATA. A registered `owner` (I or D) is valid whenever state is not IDLE.
- **IDLE, grant selection (combinational):**
  - If only one requester is valid, it is selected.
  - If both are valid, D is selected unless streak == D_STREAK_MAX, in which case I is selected.
  - If neither is valid, nothing is selected.
- **Request routing:**
  - While a selection exists (IDLE) or an owner exists (ADDR), mreq_* carries the selected/owner fields and mreq_valid = 1.
  - An I request drives mreq_size = 3'b010, mreq_strobe = 0 and mreq_data = 0.
- **IDLE transitions:**
  - mresp_addr_ok & mresp_data_ok: the transaction completes in one cycle and state stays IDLE.
  - mresp_addr_ok only: go to DATA.
  - Neither: go to ADDR.
  - In every case the selected requester is latched as owner.
- **ADDR:**
  - The grant is locked. A newly valid request from the other side is ignored.
  - On mresp_addr_ok, go to DATA, or to IDLE if mresp_data_ok is also high.
- **DATA:** mreq_valid = 0. On mresp_data_ok, go to IDLE.
- **Response routing:**
  - mresp_addr_ok and mresp_data_ok are forwarded only to the selected/owner side's *_addr_ok/*_data_ok. The non-owner side sees 0.
  - iresp_data and dresp_data always equal mresp_data.
- **Streak counter** (4 bits, saturating at D_STREAK_MAX), updated on each grant (the IDLE cycle with mreq_valid):
  - D granted while ireq_valid is high: streak + 1.
  - D granted while ireq_valid is low: streak = 0.
  - I granted: streak = 0.
- **Reset:** resetn low at a clock edge sets state = IDLE, owner = I, streak = 0. This applies mid-transaction too: the outstanding transaction is abandoned, and a late mresp_data_ok arriving in IDLE is ignored.

## Timing
- **Reset values:**
  - mreq_valid = 0 unless a requester is valid (combinational in IDLE).
  - mreq_addr, mreq_size, mreq_strobe and mreq_data = 0 when nothing is selected.
  - iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok = 0.
  - busy = 0.
- **Added latency:** zero. Requests reach memory in the same cycle they are raised from IDLE, and responses are combinational pass-through.
- **Back-to-back grants:** a new grant is possible in the cycle after DATA completes, i.e. one IDLE cycle. A single-cycle complete in IDLE allows a grant on every cycle.
- **One outstanding transaction at most:** a second address is never presented before data_ok of the first.
- **Simultaneous requests in IDLE:** resolved by the priority rule in Operation. The loser keeps its valid asserted and is served next.

## Test plan
- **I only:** ireq_valid = 1, addr 0xBFC00000; memory gives addr_ok in cycle 0 and data_ok with 0x24010001 in cycle 2 -> mreq_addr = 0xBFC00000 and strobe 0 in cycle 0; iresp_data_ok = 1 with data 0x24010001 in cycle 2; dresp_* = 0 throughout.
- **Collision:** both valid in the same cycle, D store to 0x80000010 with strobe 0xF and data 0xDEADBEEF -> D served first; I is granted on the first IDLE cycle after D's data_ok; no overlap of addresses on mreq.
- **Starvation:** D_STREAK_MAX = 4, dreq_valid and ireq_valid held high continuously, memory always single-cycle -> grant sequence D, D, D, D, I, D, ...; streak returns to 0 after the I grant.
- **Locked grant:** D valid, memory withholds addr_ok for 3 cycles; I raised in cycle 1 -> mreq fields stay D for the whole period; I is granted only after D completes.
- **Reset mid-operation:** resetn low for 1 cycle while in DATA -> next cycle busy = 0; a subsequent stray mresp_data_ok is not forwarded to either side; the following I request is granted normally.
